// File: rtl/sram_port_sequencer.sv
// sram_port_sequencer
//   Sole owner of the external 8-bit async SRAM (19-bit address). After reset
//   it fetches the video-config byte, then serves arcade-core ROM reads. It
//   interleaves ROM-loader writes, and holds the core in reset while loading
//   and for a recovery window afterwards.
//
// Optional build macro: SRAM_WRITE_VERIFY_EN
//   When defined, every write gets a read-back cycle. A mismatch sets
//   verify_err and bumps verify_cnt. A write then takes 5 cycles instead of 4.
//
// Ports:
//   clk, reset                     system clock, synchronous active-high reset
//   ldr_req/ldr_addr/ldr_data      loader write request (held until ldr_ack)
//   ldr_ack                        one-cycle write-complete pulse
//   core_addr / core_data          core ROM read address / registered read data
//   core_reset                     active-high reset to the arcade core
//   cfg_data / cfg_valid           latched video-config byte and its valid flag
//   sram_addr, sram_data_o,        SRAM pins; the top level tristates the data
//   sram_data_oe, sram_data_i,     bus when sram_data_oe is 0
//   sram_we_n
//   verify_err, verify_cnt         (SRAM_WRITE_VERIFY_EN only) write read-back status
module sram_port_sequencer #(
  parameter logic [18:0] CFG_ADDR   = 19'h08FD5,
  parameter int          CFG_DELAY  = 32,
  parameter int          CFG_SETTLE = 2,
  parameter int          CORE_HOLD  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ldr_req,
  input  logic [18:0] ldr_addr,
  input  logic [7:0]  ldr_data,
  output logic        ldr_ack,
  input  logic [18:0] core_addr,
  output logic [7:0]  core_data,
  output logic        core_reset,
  output logic [7:0]  cfg_data,
  output logic        cfg_valid,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_data_o,
  output logic        sram_data_oe,
  input  logic [7:0]  sram_data_i,
  output logic        sram_we_n
`ifdef SRAM_WRITE_VERIFY_EN
  ,
  output logic        verify_err,
  output logic [7:0]  verify_cnt
`endif
);

  typedef enum logic [3:0] {
    CFG_WAIT  = 4'd0,
    CFG_READ  = 4'd1,
    RUN       = 4'd2,
    WR_SETUP  = 4'd3,
    WR_PULSE  = 4'd4,
    WR_HOLD   = 4'd5,
    WR_VERIFY = 4'd6,
    WR_GAP    = 4'd7,
    RECOVER   = 4'd8
  } state_t;

  state_t      state_r;
  logic [15:0] cnt_r;
  logic        wr_start_s;

  // A loader write may begin from RUN, from RECOVER, or back-to-back from WR_GAP.
  always_comb begin
    wr_start_s = 1'b0;
    if (ldr_req && ((state_r == RUN) || (state_r == RECOVER) || (state_r == WR_GAP))) begin
      wr_start_s = 1'b1;
    end else begin
      wr_start_s = 1'b0;
    end
  end

  // Sequencer FSM. All pins are registered and reflect the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= CFG_WAIT;
      cnt_r        <= 16'd0;
      ldr_ack      <= 1'b0;
      core_data    <= 8'd0;
      core_reset   <= 1'b1;
      cfg_data     <= 8'd0;
      cfg_valid    <= 1'b0;
      sram_addr    <= CFG_ADDR;
      sram_data_o  <= 8'd0;
      sram_data_oe <= 1'b0;
      sram_we_n    <= 1'b1;
`ifdef SRAM_WRITE_VERIFY_EN
      verify_err   <= 1'b0;
      verify_cnt   <= 8'd0;
`endif
    end else if (wr_start_s) begin
      // Address, data and oe are set up one cycle before the we_n pulse.
      state_r      <= WR_SETUP;
      sram_addr    <= ldr_addr;
      sram_data_o  <= ldr_data;
      sram_data_oe <= 1'b1;
      sram_we_n    <= 1'b1;
      core_reset   <= 1'b1;
      ldr_ack      <= 1'b0;
      core_data    <= sram_data_i;
    end else begin
      case (state_r)
        CFG_WAIT: begin
          sram_addr <= CFG_ADDR;
          if (cnt_r == 16'(CFG_DELAY - 1)) begin
            state_r <= CFG_READ;
            cnt_r   <= 16'd0;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
          end
        end
        CFG_READ: begin
          sram_addr <= CFG_ADDR;
          if (cnt_r == 16'(CFG_SETTLE - 1)) begin
            cfg_data   <= sram_data_i;
            cfg_valid  <= 1'b1;
            core_reset <= 1'b0;
            cnt_r      <= 16'd0;
            state_r    <= RUN;
          end else begin
            cnt_r      <= cnt_r + 16'd1;
          end
        end
        RUN: begin
          sram_addr    <= core_addr;
          core_data    <= sram_data_i;
          sram_we_n    <= 1'b1;
          sram_data_oe <= 1'b0;
        end
        WR_SETUP: begin
          sram_we_n <= 1'b0;
          state_r   <= WR_PULSE;
        end
        WR_PULSE: begin
          sram_we_n <= 1'b1;
`ifdef SRAM_WRITE_VERIFY_EN
          ldr_ack   <= 1'b0;
`else
          ldr_ack   <= 1'b1;
`endif
          state_r   <= WR_HOLD;
        end
        WR_HOLD: begin
          // Bus released here; address stays put through the gap.
          sram_data_oe <= 1'b0;
`ifdef SRAM_WRITE_VERIFY_EN
          ldr_ack      <= 1'b1;
          state_r      <= WR_VERIFY;
`else
          ldr_ack      <= 1'b0;
          state_r      <= WR_GAP;
`endif
        end
`ifdef SRAM_WRITE_VERIFY_EN
        WR_VERIFY: begin
          // Bus is released and the address is unchanged, so sram_data_i is the stored byte.
          ldr_ack <= 1'b0;
          if (sram_data_i != sram_data_o) begin
            verify_err <= 1'b1;
            if (verify_cnt != 8'hFF) begin
              verify_cnt <= verify_cnt + 8'd1;
            end else begin
              verify_cnt <= verify_cnt;
            end
          end else begin
            verify_err <= verify_err;
          end
          state_r <= WR_GAP;
        end
`endif
        WR_GAP: begin
          // No follow-on request (handled above), so start the core recovery window.
          cnt_r   <= 16'(CORE_HOLD);
          state_r <= RECOVER;
        end
        RECOVER: begin
          sram_addr <= core_addr;
          core_data <= sram_data_i;
          if (cnt_r == 16'd0) begin
            core_reset <= 1'b0;
            state_r    <= RUN;
          end else begin
            cnt_r      <= cnt_r - 16'd1;
          end
        end
        default: begin
          state_r      <= CFG_WAIT;
          cnt_r        <= 16'd0;
          ldr_ack      <= 1'b0;
          core_reset   <= 1'b1;
          sram_addr    <= CFG_ADDR;
          sram_data_oe <= 1'b0;
          sram_we_n    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_sequencer.sv
module tb_sram_port_sequencer;

  localparam logic [18:0] CFG_ADDR  = 19'h08FD5;
  localparam int          CORE_HOLD = 256;
`ifdef SRAM_WRITE_VERIFY_EN
  localparam int WR_LEN  = 5;
  localparam int ACK_CYC = 4;
`else
  localparam int WR_LEN  = 4;
  localparam int ACK_CYC = 3;
`endif

  logic        clk;
  logic        reset;
  logic        ldr_req;
  logic [18:0] ldr_addr;
  logic [7:0]  ldr_data;
  logic        ldr_ack;
  logic [18:0] core_addr;
  logic [7:0]  core_data;
  logic        core_reset;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic [18:0] sram_addr;
  logic [7:0]  sram_data_o;
  logic        sram_data_oe;
  logic [7:0]  sram_data_i;
  logic        sram_we_n;
`ifdef SRAM_WRITE_VERIFY_EN
  logic        verify_err;
  logic [7:0]  verify_cnt;
`endif

  logic [7:0] mem [0:524287];
  logic [7:0] rd_mask;
  int         pass_cnt;
  int         chk_cnt;
  int         inv_bad;

  sram_port_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .ldr_req      (ldr_req),
    .ldr_addr     (ldr_addr),
    .ldr_data     (ldr_data),
    .ldr_ack      (ldr_ack),
    .core_addr    (core_addr),
    .core_data    (core_data),
    .core_reset   (core_reset),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .sram_addr    (sram_addr),
    .sram_data_o  (sram_data_o),
    .sram_data_oe (sram_data_oe),
    .sram_data_i  (sram_data_i),
    .sram_we_n    (sram_we_n)
`ifdef SRAM_WRITE_VERIFY_EN
    ,
    .verify_err   (verify_err),
    .verify_cnt   (verify_cnt)
`endif
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM model: combinational read (with optional stuck-at-0 on bit 0).
  assign sram_data_i = mem[sram_addr] & rd_mask;

  // SRAM write: a byte is stored when we_n is low with the bus driven.
  always @(posedge clk) begin
    if (!sram_we_n && sram_data_oe) mem[sram_addr] <= sram_data_o;
  end

  // Invariant watch: we_n low without the data bus driven is never legal.
  always @(negedge clk) begin
    if (!sram_we_n && !sram_data_oe) inv_bad++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one loader write and wait (bounded) for its ack, then drop ldr_req.
  task automatic do_write(input logic [18:0] a, input logic [7:0] d, output int got);
    got = 0;
    ldr_addr = a;
    ldr_data = d;
    ldr_req  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ldr_ack) begin
        got = c;
        ldr_req = 1'b0;
        break;
      end
    end
    ldr_req = 1'b0;
  endtask

  int bad;
  int ack_n;
  int ack_at;
  int wel;
  int pulse_bad;
  int hold_bad;
  int zero_cyc;
  int first_ack;
  int last_ack;
  int gap_bad;
  int got;

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    inv_bad  = 0;
    rd_mask  = 8'hFF;
    for (int i = 0; i < 524288; i++) mem[i] = 8'h00;
    mem[CFG_ADDR]  = 8'h03;
    mem[19'h00100] = 8'hA5;
    reset     = 1'b1;
    ldr_req   = 1'b0;
    ldr_addr  = 19'd0;
    ldr_data  = 8'd0;
    core_addr = 19'd0;

    // Reset state
    tick();
    reset = 1'b0;
    chk("rst_ack", ldr_ack, 1'b0);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_cfg_valid", cfg_valid, 1'b0);
    chk("rst_cfg_data", cfg_data, 8'h00);
    chk("rst_core_data", core_data, 8'h00);
    chk("rst_addr", sram_addr, CFG_ADDR);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_oe", sram_data_oe, 1'b0);

    // 1. Power-on config read
    bad = 0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (sram_addr != CFG_ADDR) bad++;
      if (c == 33) begin
        chk("cfg_valid_c33", cfg_valid, 1'b0);
        chk("core_reset_c33", core_reset, 1'b1);
      end
      if (c == 34) begin
        chk("cfg_valid_c34", cfg_valid, 1'b1);
        chk("cfg_data_c34", cfg_data, 8'h03);
        chk("core_reset_run", core_reset, 1'b0);
      end
    end
    chk("cfg_addr_hold", bad, 0);

    // 2. Core read latency
    core_addr = 19'h00100;
    tick();
    chk("rd_addr_1cyc", sram_addr, 19'h00100);
    chk("rd_data_1cyc", core_data, 8'h03);
    tick();
    chk("rd_data_2cyc", core_data, 8'hA5);
    chk("rd_we_n", sram_we_n, 1'b1);

    // 3. Single write
    ldr_addr = 19'h01234;
    ldr_data = 8'h5A;
    ldr_req  = 1'b1;
    ack_n = 0; ack_at = 0; wel = 0; pulse_bad = 0; hold_bad = 0; zero_cyc = 0;
    for (int c = 1; c <= WR_LEN + CORE_HOLD + 20; c++) begin
      tick();
      if (c == 1) begin
        chk("wr_setup_core_reset", core_reset, 1'b1);
        chk("wr_setup_oe", sram_data_oe, 1'b1);
        chk("wr_setup_we_n", sram_we_n, 1'b1);
      end
      if (!sram_we_n) begin
        wel++;
        if (sram_addr != 19'h01234 || sram_data_o != 8'h5A || !sram_data_oe) pulse_bad++;
      end
      if (ldr_ack) begin
        ack_n++;
        ack_at = c;
        if (sram_addr != 19'h01234) hold_bad++;
        ldr_req = 1'b0;
      end
      if (!core_reset) begin
        zero_cyc = c;
        break;
      end
    end
    chk("wr_ack_count", ack_n, 1);
    chk("wr_ack_cycle", ack_at, ACK_CYC);
    chk("wr_we_low_cycles", wel, 1);
    chk("wr_pulse_stable", pulse_bad, 0);
    chk("wr_addr_after_pulse", hold_bad, 0);
    chk("wr_mem", mem[19'h01234], 8'h5A);
    chk("wr_core_reset_release", zero_cyc, WR_LEN + CORE_HOLD + 2);

    // 4. Burst of 16 back-to-back writes
    ldr_addr = 19'd0;
    ldr_data = 8'hC0;
    ldr_req  = 1'b1;
    ack_n = 0; first_ack = 0; last_ack = 0; gap_bad = 0; zero_cyc = 0;
    for (int c = 1; c <= 16 * WR_LEN + CORE_HOLD + 40; c++) begin
      tick();
      if (ldr_ack) begin
        if (ack_n == 0) first_ack = c;
        else if (c - last_ack != WR_LEN) gap_bad++;
        last_ack = c;
        ack_n++;
        if (ack_n < 16) begin
          ldr_addr = 19'(ack_n);
          ldr_data = 8'hC0 | 8'(ack_n);
        end else begin
          ldr_req = 1'b0;
        end
      end
      if (!core_reset) begin
        zero_cyc = c;
        break;
      end
    end
    chk("burst_ack_count", ack_n, 16);
    chk("burst_first_ack", first_ack, ACK_CYC);
    chk("burst_ack_spacing", gap_bad, 0);
    chk("burst_core_reset_hold", zero_cyc - last_ack, CORE_HOLD + 3);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem[i] != (8'hC0 | 8'(i))) bad++;
    end
    chk("burst_mem", bad, 0);

`ifdef SRAM_WRITE_VERIFY_EN
    // 6. Write verify with stuck-at-0 on bit 0
    rd_mask = 8'hFE;
    chk("vfy_err_init", verify_err, 1'b0);
    do_write(19'h00200, 8'h01, got);
    tick();
    chk("vfy_ack1", got, ACK_CYC);
    chk("vfy_err_set", verify_err, 1'b1);
    chk("vfy_cnt_1", verify_cnt, 8'd1);
    do_write(19'h00201, 8'h02, got);
    tick();
    chk("vfy_ack2", got, ACK_CYC);
    chk("vfy_cnt_still_1", verify_cnt, 8'd1);
    chk("vfy_err_sticky", verify_err, 1'b1);
    rd_mask = 8'hFF;
`endif

    // 5. Reset during WR_PULSE
    ldr_addr = 19'h00300;
    ldr_data = 8'h77;
    ldr_req  = 1'b1;
    tick();
    tick();
    chk("mid_wr_we_low", sram_we_n, 1'b0);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    ldr_req = 1'b0;
    chk("mid_rst_we_n", sram_we_n, 1'b1);
    chk("mid_rst_oe", sram_data_oe, 1'b0);
    chk("mid_rst_ack", ldr_ack, 1'b0);
    chk("mid_rst_cfg_valid", cfg_valid, 1'b0);
    chk("mid_rst_core_reset", core_reset, 1'b1);
    chk("mid_rst_addr", sram_addr, CFG_ADDR);
    ack_n = 0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (ldr_ack) ack_n++;
      if (c == 33) chk("rerun_cfg_valid_c33", cfg_valid, 1'b0);
      if (c == 34) begin
        chk("rerun_cfg_valid_c34", cfg_valid, 1'b1);
        chk("rerun_cfg_data", cfg_data, 8'h03);
      end
    end
    chk("rerun_no_ack", ack_n, 0);
    chk("inv_we_without_oe", inv_bad, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
